// File: rtl/rx_if.sv
// Serial receive-side bus: line, oversample tick, consumer ack and received byte/status.
interface rx_if;
  logic       rxd;
  logic       rxen;
  logic       rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;

  modport slave  (input rxd, rxen, rd, output rx_data, rx_valid, frame_err, overrun_err);
  modport master (output rxd, rxen, rd, input rx_data, rx_valid, frame_err, overrun_err);
endinterface

// File: rtl/rx.sv
// 8N1 asynchronous receiver: oversampled on an external tick, mid-bit sampling,
// start/stop validation, byte held until acknowledged.
module rx #(
  parameter int OSR = 16
) (
  input  logic clk,
  input  logic n_rst,
  rx_if.slave  bus
);
  localparam int SW = $clog2(OSR);
  localparam logic [SW-1:0] HALF = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OSR - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          sync_q, rxs_q;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= bus.rxd;
      rxs_q   <= sync_q;
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    // Ack clears first; a good stop in the same cycle overrides below.
    if (bus.rd) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    case (state_q)
      IDLE: if (bus.rxen && !rxs_q) begin
        state_d = START;
        scnt_d  = '0;
      end
      START: if (bus.rxen) begin
        if (scnt_q == HALF) begin
          scnt_d = '0;
          if (!rxs_q) begin
            state_d = DATA;
            bcnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      DATA: if (bus.rxen) begin
        if (scnt_q == LAST) begin
          shreg_d = {rxs_q, shreg_q[7:1]};
          scnt_d  = '0;
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = STOP;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      STOP: if (bus.rxen) begin
        if (scnt_q == LAST) begin
          scnt_d = '0;
          if (rxs_q) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            ferr_d  = 1'b0;
            if (valid_q && !bus.rd) ovr_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      // Line held low after a bad stop: wait for idle before hunting a start.
      BRK: if (bus.rxen && rxs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun_err = ovr_q;
endmodule

// File: tb/tb_rx.sv
// Directed bench for rx: frames driven tick by tick, outputs checked at negedge.
module tb_rx;
  localparam int OSR = 16;
  localparam int FT  = 10 * OSR;

  logic clk = 1'b0;
  logic n_rst;
  int   div;
  int   tests = 0;
  int   fails = 0;

  rx_if bus ();
  rx #(.OSR(OSR)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    bus.rxen = 1'b1;
    @(negedge clk);
    if (div > 1) begin
      bus.rxen = 1'b0;
      repeat (div - 1) @(negedge clk);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic stop, input int from, input int to, input int rd_at);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = from; i < to; i++) begin
      bus.rxd = fr[i / OSR];
      bus.rd  = (i == rd_at);
      tick();
    end
    bus.rd = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    repeat (n) tick();
  endtask

  task automatic ack();
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  initial begin
    div      = 1;
    n_rst    = 1'b1;
    bus.rxd  = 1'b1;
    bus.rxen = 1'b0;
    bus.rd   = 1'b0;

    // Reset with the line toggling
    for (int i = 0; i < 3; i++) begin
      bus.rxd = i[0];
      @(negedge clk);
    end
    chk("rst_data", bus.rx_data, 8'h00);
    chk("rst_valid", {7'd0, bus.rx_valid}, 8'd0);
    chk("rst_ferr", {7'd0, bus.frame_err}, 8'd0);
    chk("rst_ovr", {7'd0, bus.overrun_err}, 8'd0);
    n_rst = 1'b0;
    idle(8);

    // Good frame 0xA5: valid rises exactly on stop-sample tick (index 154)
    drive(8'hA5, 1'b1, 0, 154, -1);
    chk("a5_early_valid", {7'd0, bus.rx_valid}, 8'd0);
    drive(8'hA5, 1'b1, 154, 155, -1);
    chk("a5_valid", {7'd0, bus.rx_valid}, 8'd1);
    chk("a5_data", bus.rx_data, 8'hA5);
    drive(8'hA5, 1'b1, 155, FT, -1);
    ack();
    chk("a5_rd_valid", {7'd0, bus.rx_valid}, 8'd0);
    chk("a5_rd_data", bus.rx_data, 8'hA5);

    // Start glitch then a real frame
    bus.rxd = 1'b0;
    repeat (4) tick();
    idle(30);
    chk("glitch_valid", {7'd0, bus.rx_valid}, 8'd0);
    drive(8'h3C, 1'b1, 0, FT, -1);
    chk("3c_data", bus.rx_data, 8'h3C);
    chk("3c_valid", {7'd0, bus.rx_valid}, 8'd1);
    ack();

    // Framing error, long break, then recovery
    drive(8'h3C, 1'b0, 0, FT, -1);
    bus.rxd = 1'b0;
    repeat (40) tick();
    idle(20);
    chk("fe_ferr", {7'd0, bus.frame_err}, 8'd1);
    chk("fe_valid", {7'd0, bus.rx_valid}, 8'd0);
    drive(8'h55, 1'b1, 0, FT, -1);
    chk("55_data", bus.rx_data, 8'h55);
    chk("55_valid", {7'd0, bus.rx_valid}, 8'd1);
    chk("55_ferr", {7'd0, bus.frame_err}, 8'd0);
    ack();
    idle(4);

    // Overrun: two back-to-back frames without ack
    drive(8'h11, 1'b1, 0, FT, -1);
    drive(8'h22, 1'b1, 0, FT, -1);
    chk("ov_data", bus.rx_data, 8'h22);
    chk("ov_ovr", {7'd0, bus.overrun_err}, 8'd1);
    chk("ov_valid", {7'd0, bus.rx_valid}, 8'd1);
    ack();
    chk("ov_rd_valid", {7'd0, bus.rx_valid}, 8'd0);
    chk("ov_rd_ovr", {7'd0, bus.overrun_err}, 8'd0);

    // Ack coinciding with the good stop sample of the next byte
    drive(8'h33, 1'b1, 0, FT, -1);
    drive(8'h44, 1'b1, 0, FT, 154);
    chk("sim_data", bus.rx_data, 8'h44);
    chk("sim_valid", {7'd0, bus.rx_valid}, 8'd1);
    chk("sim_ovr", {7'd0, bus.overrun_err}, 8'd0);

    // Reset during data bit 4
    drive(8'h99, 1'b1, 0, 5 * OSR + 8, -1);
    n_rst = 1'b1;
    bus.rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_data", bus.rx_data, 8'h00);
    chk("mrst_valid", {7'd0, bus.rx_valid}, 8'd0);
    chk("mrst_ferr", {7'd0, bus.frame_err}, 8'd0);
    chk("mrst_ovr", {7'd0, bus.overrun_err}, 8'd0);
    n_rst = 1'b0;
    idle(4);

    // Tick every third clock
    div = 3;
    drive(8'h81, 1'b1, 0, FT, -1);
    idle(2);
    chk("div3_data", bus.rx_data, 8'h81);
    chk("div3_valid", {7'd0, bus.rx_valid}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rx.md
# rx

Serial receiver for 8N1 asynchronous frames: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), idle high. It is the receiving counterpart of the existing serial transmitter and shares its line format. It oversamples the line on an external enable tick, validates start and stop bits, and holds each received byte until the consumer acknowledges it.

## Interface
- OSR, 16, oversample ticks per bit; even, ≥4.
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  reset; synchronous, active-high (1 = reset).
- rxd  in  1  asynchronous serial line, idle high.
- rxen  in  1  oversample tick, OSR pulses per bit period; all counters and sampling advance only when high.
- rd  in  1  consumer acknowledge; single-cycle pulse.
- rx_data  out  8  last good byte.
- rx_valid  out  1  level; byte in rx_data not yet acknowledged.
- frame_err  out  1  last frame had stop bit = 0.
- overrun_err  out  1  sticky; a good byte overwrote an unacknowledged one.

## Operation
- rxd passes a 2-FF synchronizer (both FFs reset to 1) giving rxd_s; all decisions use rxd_s.
- scnt: sample counter, width $clog2(OSR). bcnt: 3-bit data-bit counter. shreg: 8-bit shift register.
- States:
  - IDLE: on a tick with rxd_s=0, go to START with scnt=0.
  - START: on each tick, check scnt. If scnt=OSR/2-1 and rxd_s=0, go to DATA with scnt=0 and bcnt=0. If scnt=OSR/2-1 and rxd_s=1, treat it as a glitch and return to IDLE. Otherwise scnt+1.
  - DATA: on each tick, check scnt. If scnt=OSR-1, set shreg={rxd_s,shreg[7:1]}, scnt=0, bcnt+1; on the bcnt=7 sample, go to STOP. Otherwise scnt+1.
  - STOP: on a tick with scnt=OSR-1, sample rxd_s.
    - rxd_s=1: rx_data=shreg, rx_valid=1, frame_err=0. If rx_valid was already 1 and rd is not high this cycle, set overrun_err=1. Go to IDLE.
    - rxd_s=0: frame_err=1; rx_data and rx_valid are unchanged. Go to BRK.
  - BRK: wait for a tick with rxd_s=1, then go to IDLE. No start detection occurs while in BRK.
- rd=1 clears rx_valid and overrun_err next edge, unless a good stop is sampled in the same cycle. In that case rx_valid stays 1, rx_data takes the new byte, and overrun_err is cleared.
- rxen=0: state, scnt, bcnt and shreg hold.
- Unused state encodings go to IDLE.

## Timing
- Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, overrun_err=0; state=IDLE; scnt=0, bcnt=0, shreg=0; synchronizer = 1.
- n_rst mid-frame aborts the frame. Reception restarts from IDLE on the first clock after n_rst deasserts.
- Synchronizer latency: 2 clk from the rxd edge to rxd_s.
- Let T0 be the tick on which IDLE sees rxd_s=0.
  - Start-bit validation: tick T0+OSR/2.
  - Data bit k (k=0..7) sampled at tick T0+OSR/2+OSR·(k+1).
  - Stop bit sampled at T0+OSR/2+9·OSR; this is T0+152 for OSR=16.
- Outputs are registered. rx_valid and rx_data change on the clk edge that ends the stop-sample tick cycle.
- Back-to-back frames are supported. The next start edge may arrive one tick after the stop sample; IDLE detects it on the next tick.

## Test plan
- Reset: hold n_rst=1 for 3 clk with rxd toggling -> rx_data=0x00, rx_valid=0, frame_err=0, overrun_err=0.
- Good frame (OSR=16, rxen=1 every clk): send 0xA5 -> rx_data=0xA5 and rx_valid=1 exactly at tick T0+152. Pulse rd -> rx_valid=0 next clk, rx_data still 0xA5.
- Start glitch: rxd low for 4 ticks, then high -> returns to IDLE, rx_valid stays 0. A following frame of 0x3C is received correctly.
- Framing error: send 0x3C with stop bit=0, then hold rxd low 40 ticks, then high -> frame_err=1, rx_valid=0, no start detected while low. Then send 0x55 -> rx_data=0x55, rx_valid=1, frame_err=0.
- Overrun and simultaneous rd:
  - Send 0x11 then 0x22 with no rd -> rx_data=0x22, overrun_err=1. rd -> rx_valid=0, overrun_err=0.
  - Send 0x33, then 0x44 with rd pulsed on the 0x44 stop-sample cycle -> rx_data=0x44, rx_valid=1, overrun_err=0.
- Reset mid-frame and rxen gating:
  - Assert n_rst during data bit 4 -> all outputs return to reset values.
  - Send 0x81 with rxen high only every 3rd clk -> rx_data=0x81, rx_valid=1.
